tdm_demux16: RTL and testbench
==============================

Name: tdm_demux16

Overview:
- Receive end of the team's 16:1 mux serializer path. A mux scans channels 0..N-1 onto one wire, one channel per clock.
- This block rebuilds the parallel word from that serial stream, with 4, 8 or 16 channels per frame (the mux4/mux8/mux16 widths).
- The write slot is picked by a channel counter driving a 4-to-16 decoder. The assembled word is presented in a hold register with a one-cycle done strobe.

Parameters:
- MAXCH, 16, maximum channel count; sets the dout width and the counter range (fixed at 16 for this revision).

Ports:
- clk  input  1  system clock, all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- din  input  1  serial sample for the current channel
- en  input  1  sample-valid; low stalls collection
- sync  input  1  frame start; din in this cycle is channel 0
- mode  input  2  frame size: 00=4 channels, 01=8, 10=16, 11=reserved (treated as 16)
- dout  output  16  last completed frame; bit i = channel i
- done  output  1  one-cycle pulse: dout just updated
- busy  output  1  high while a frame is being collected
- ch  output  4  channel index expected next
- abort  output  1  one-cycle pulse: the frame in progress was discarded

Behaviour:
- Reset values (synchronous): state=IDLE, dout=0, done=0, busy=0, ch=0, abort=0, shadow=0, latched size=16.
- Clock and reset: one clock, clk. Reset is synchronous and active-high. reset wins over all other inputs in the same cycle.
- States: IDLE and COLLECT. busy=1 exactly in COLLECT.
- IDLE:
  - en&sync: latch mode into the size register N, write din to shadow[0], clear shadow[15:1], set ch=1, go to COLLECT.
  - If N would be 1 the frame completes immediately; it never is, since the minimum N is 4.
  - sync without en: ignored.
- COLLECT, en=1, sync=0:
  - shadow[ch] <= din, ch <= ch+1.
  - If ch==N-1: dout <= shadow with bit ch = din, bits >= N forced 0; done=1 next cycle; ch <= 0; go to IDLE.
- COLLECT, en=0: hold everything. No sample; ch, shadow and state are unchanged. sync is ignored while en=0.
- COLLECT, en&sync (restart): abort=1 next cycle, no done. Restart as from IDLE: relatch mode, shadow[0]=din, ch=1, stay in COLLECT.
- mode changes mid-frame are ignored. N is latched only on an accepted sync.
- Latency: the last sample is accepted on edge k. dout and done are visible from edge k until k+1. dout holds until the next completed frame.
- Back-to-back frames: sync may be asserted in the cycle right after the last sample. No gap cycle is required, and throughput is N samples per frame.
- ch wrap-around: in 16-mode ch goes 15 -> 0 on completion, never to an undefined value. ch never exceeds N-1 in COLLECT.
- done and abort are never high in the same cycle. Neither is ever high for more than one cycle.

Decomposition:
- Package tdm_pkg holds:
  - state enum {IDLE, COLLECT}
  - mode enum {M4=2'b00, M8=2'b01, M16=2'b10}
  - function nch(mode) returning 4/8/16 (11 -> 16)
  - constant MAXCH=16
- Sub-module decoder4_16 (4-bit index in, enable in, 16-bit one-hot out). It supplies the shadow write enables and is the inverse of the mux tree's select path.
- Counter, FSM and registers stay in tdm_demux16.

Test Plan:
- 16-mode frame: reset, then sync+en with din serial 1,0,1,1,0,0,0,0,0,0,0,0,0,0,0,1 (ch0 first) -> done pulses once, 1 cycle after the 16th sample; dout=16'h800D; busy drops the same cycle.
- 4-mode frame followed by 8-mode frame back-to-back: 4-mode bits 1,1,0,1 -> dout=16'h000B, done. On the next cycle sync in 8-mode, bits all 1 -> dout=16'h00FF, no gap cycle.
- Stall: 8-mode frame with en low for 3 cycles after channel 2 -> ch holds at 3, no sample taken; final dout equals the unstalled result; done 3 cycles later than without the stall.
- Restart: sync+en at channel 5 of a 16-mode frame -> abort pulses 1 cycle, no done, ch=1; the new frame completes normally with only the new bits in dout.
- Reset mid-frame: reset at channel 9 -> next cycle busy=0, ch=0, dout=0, done=0, abort=0. The following full frame is decoded correctly.
- mode=11 and a mid-frame mode change: mode=11 -> a 16-channel frame. Switching mode to 00 at channel 6 -> the frame still completes after 16 samples.

Source files
------------

// File: rtl/tdm_pkg.sv
// tdm_pkg: shared types and helpers for the TDM demultiplexer.
//   state_e    : collector FSM states
//   mode_e     : frame-size encoding seen on the mode input
//   nch()      : channels per frame for a mode code (reserved 11 -> 16)
//   frame_mask : ones in bits [n-1:0], used to scrub bits beyond the frame
package tdm_pkg;

  localparam int MAXCH = 16;

  typedef enum logic {
    IDLE,
    COLLECT
  } state_e;

  typedef enum logic [1:0] {
    M4  = 2'b00,
    M8  = 2'b01,
    M16 = 2'b10
  } mode_e;

  function automatic logic [4:0] nch(input logic [1:0] m);
    case (m)
      M4:      return 5'd4;
      M8:      return 5'd8;
      default: return 5'd16;  // M16 and the reserved code
    endcase
  endfunction

  function automatic logic [MAXCH-1:0] frame_mask(input logic [4:0] n);
    logic [MAXCH-1:0] m;
    m = '0;
    for (int i = 0; i < MAXCH; i++) m[i] = (5'(i) < n);
    return m;
  endfunction

endpackage

// File: rtl/tdm_demux16_decoder.sv
// decoder4_16: 4-to-16 one-hot decoder with enable.
//   idx_i    : slot index
//   en_i     : when low the output is all zeros
//   onehot_o : bit idx_i set when enabled
// Mirrors the mux tree's select path; here it gates shadow-register writes.
module decoder4_16 (
  input  logic [3:0]  idx_i,
  input  logic        en_i,
  output logic [15:0] onehot_o
);

  assign onehot_o = en_i ? (16'd1 << idx_i) : 16'd0;

endmodule

// File: rtl/tdm_demux16.sv
// tdm_demux16: rebuilds a 4/8/16-bit parallel word from a one-channel-per-clock
// serial TDM stream.
//   clk, reset : clock, synchronous active-high reset
//   din        : serial sample for the current channel
//   en         : sample valid; low freezes collection
//   sync       : frame start, din in this cycle is channel 0
//   mode       : frame size (00=4, 01=8, 10/11=16), latched on accepted sync
//   dout       : last completed frame, bit i = channel i
//   done       : one-cycle pulse when dout updates
//   busy       : high while collecting
//   ch         : channel index expected next
//   abort      : one-cycle pulse when a frame in progress is restarted
module tdm_demux16
  import tdm_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  input  logic             en,
  input  logic             sync,
  input  logic [1:0]       mode,
  output logic [MAXCH-1:0] dout,
  output logic             done,
  output logic             busy,
  output logic [3:0]       ch,
  output logic             abort
);

  state_e           state_q, state_d;
  logic [4:0]       n_q, n_d;          // latched channels per frame
  logic [3:0]       ch_q, ch_d;
  logic [MAXCH-1:0] shadow_q, shadow_d;
  logic [MAXCH-1:0] dout_q, dout_d;
  logic             done_q, done_d;
  logic             abort_q, abort_d;

  logic             sample;
  logic [MAXCH-1:0] wr_oh;
  logic             last;

  // A plain sample only happens in COLLECT with en and no restart.
  assign sample = (state_q == COLLECT) && en && !sync;
  assign last   = (ch_q == 4'(n_q - 5'd1));

  decoder4_16 u_dec (
    .idx_i    (ch_q),
    .en_i     (sample),
    .onehot_o (wr_oh)
  );

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    ch_d     = ch_q;
    shadow_d = shadow_q;
    dout_d   = dout_q;
    done_d   = 1'b0;
    abort_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (en && sync) begin
          n_d      = nch(mode);
          shadow_d = {{(MAXCH-1){1'b0}}, din};
          ch_d     = 4'd1;
          state_d  = COLLECT;
        end
      end
      COLLECT: begin
        if (en && sync) begin
          // Restart: drop the partial frame and begin again at channel 0.
          abort_d  = 1'b1;
          n_d      = nch(mode);
          shadow_d = {{(MAXCH-1){1'b0}}, din};
          ch_d     = 4'd1;
        end else if (en) begin
          shadow_d = (shadow_q & ~wr_oh) | ({MAXCH{din}} & wr_oh);
          if (last) begin
            dout_d  = shadow_d & frame_mask(n_q);
            done_d  = 1'b1;
            ch_d    = 4'd0;
            state_d = IDLE;
          end else begin
            ch_d = ch_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      n_q      <= 5'd16;
      ch_q     <= 4'd0;
      shadow_q <= '0;
      dout_q   <= '0;
      done_q   <= 1'b0;
      abort_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      ch_q     <= ch_d;
      shadow_q <= shadow_d;
      dout_q   <= dout_d;
      done_q   <= done_d;
      abort_q  <= abort_d;
    end
  end

  assign dout  = dout_q;
  assign done  = done_q;
  assign busy  = (state_q == COLLECT);
  assign ch    = ch_q;
  assign abort = abort_q;

endmodule

// File: tb/tb_tdm_demux16.sv
module tb_tdm_demux16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        din = 1'b0;
  logic        en = 1'b0;
  logic        sync = 1'b0;
  logic [1:0]  mode = 2'b10;
  logic [15:0] dout;
  logic        done, busy, abort;
  logic [3:0]  ch;

  int errors = 0;
  int checks = 0;

  tdm_demux16 dut (
    .clk   (clk),
    .reset (reset),
    .din   (din),
    .en    (en),
    .sync  (sync),
    .mode  (mode),
    .dout  (dout),
    .done  (done),
    .busy  (busy),
    .ch    (ch),
    .abort (abort)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, en, sync, din;
    logic [1:0]  mode;
    logic [15:0] xdout;
    logic        xdone, xbusy;
    logic [3:0]  xch;
    logic        xabort;
  } vec_t;

  vec_t tbl[$];

  // Drive one cycle of inputs, then check outputs 1 time unit after the edge.
  task automatic cyc(input string nm, input logic r, input logic e, input logic s,
                     input logic d, input logic [1:0] m, input logic [15:0] xd,
                     input logic xdn, input logic xb, input logic [3:0] xc,
                     input logic xa);
    reset = r; en = e; sync = s; din = d; mode = m;
    @(posedge clk);
    #1;
    checks++;
    if ({dout, done, busy, ch, abort} !== {xd, xdn, xb, xc, xa}) begin
      errors++;
      $display("FAIL %s: got dout=%h done=%b busy=%b ch=%0d abort=%b, want dout=%h done=%b busy=%b ch=%0d abort=%b",
               nm, dout, done, busy, ch, abort, xd, xdn, xb, xc, xa);
    end
  endtask

  function automatic void add(input logic r, input logic e, input logic s, input logic d,
                              input logic [1:0] m, input logic [15:0] xd, input logic xdn,
                              input logic xb, input logic [3:0] xc, input logic xa);
    vec_t v;
    v.rst = r; v.en = e; v.sync = s; v.din = d; v.mode = m;
    v.xdout = xd; v.xdone = xdn; v.xbusy = xb; v.xch = xc; v.xabort = xa;
    tbl.push_back(v);
  endfunction

  // Unstalled frame: mode m0 for samples before sw, m1 from sw on.
  function automatic void add_frame(input logic [1:0] m0, input logic [1:0] m1, input int sw,
                                    input int n, input logic [15:0] bits,
                                    input logic [15:0] prev, input logic [15:0] fin);
    for (int i = 0; i < n; i++) begin
      if (i == n - 1) add(0, 1, 0, bits[i], (i < sw) ? m0 : m1, fin, 1, 0, 4'd0, 0);
      else            add(0, 1, (i == 0), bits[i], (i < sw) ? m0 : m1, prev, 0, 1, 4'(i + 1), 0);
    end
  endfunction

  initial begin
    logic [15:0] nb;

    // reset state
    add(1, 0, 0, 0, 2'b10, 16'h0000, 0, 0, 4'd0, 0);
    // 16-mode frame 1,0,1,1,0..0,1
    add_frame(2'b10, 2'b10, 16, 16, 16'h800D, 16'h0000, 16'h800D);
    add(0, 0, 0, 0, 2'b10, 16'h800D, 0, 0, 4'd0, 0);
    // 4-mode then 8-mode back to back
    add_frame(2'b00, 2'b00, 16, 4, 16'h000B, 16'h800D, 16'h000B);
    add_frame(2'b01, 2'b01, 16, 8, 16'h00FF, 16'h000B, 16'h00FF);
    add(0, 0, 0, 0, 2'b01, 16'h00FF, 0, 0, 4'd0, 0);
    // 8-mode frame 0x96 with a 3-cycle stall after channel 2 (sync ignored while en=0)
    add(0, 1, 1, 0, 2'b01, 16'h00FF, 0, 1, 4'd1, 0);
    add(0, 1, 0, 1, 2'b01, 16'h00FF, 0, 1, 4'd2, 0);
    add(0, 1, 0, 1, 2'b01, 16'h00FF, 0, 1, 4'd3, 0);
    add(0, 0, 0, 1, 2'b01, 16'h00FF, 0, 1, 4'd3, 0);
    add(0, 0, 1, 1, 2'b00, 16'h00FF, 0, 1, 4'd3, 0);
    add(0, 0, 0, 1, 2'b01, 16'h00FF, 0, 1, 4'd3, 0);
    add(0, 1, 0, 0, 2'b01, 16'h00FF, 0, 1, 4'd4, 0);
    add(0, 1, 0, 1, 2'b01, 16'h00FF, 0, 1, 4'd5, 0);
    add(0, 1, 0, 0, 2'b01, 16'h00FF, 0, 1, 4'd6, 0);
    add(0, 1, 0, 0, 2'b01, 16'h00FF, 0, 1, 4'd7, 0);
    add(0, 1, 0, 1, 2'b01, 16'h0096, 1, 0, 4'd0, 0);
    // reserved mode 11 -> 16 channels
    add_frame(2'b11, 2'b11, 16, 16, 16'hA5C3, 16'h0096, 16'hA5C3);
    // mode switched to 00 at channel 6 must not shorten the frame
    add_frame(2'b10, 2'b00, 6, 16, 16'h0F81, 16'hA5C3, 16'h0F81);
    add(0, 0, 0, 0, 2'b00, 16'h0F81, 0, 0, 4'd0, 0);

    for (int i = 0; i < tbl.size(); i++)
      cyc($sformatf("vec%0d", i), tbl[i].rst, tbl[i].en, tbl[i].sync, tbl[i].din, tbl[i].mode,
          tbl[i].xdout, tbl[i].xdone, tbl[i].xbusy, tbl[i].xch, tbl[i].xabort);

    // Restart at channel 5: old ones must not leak into the new frame 0x4002.
    for (int i = 0; i < 5; i++)
      cyc("restart_pre", 0, 1, (i == 0), 1, 2'b10, 16'h0F81, 0, 1, 4'(i + 1), 0);
    cyc("restart_sync", 0, 1, 1, 0, 2'b10, 16'h0F81, 0, 1, 4'd1, 1);
    nb = 16'h4002;
    for (int i = 1; i < 16; i++) begin
      if (i == 15) cyc("restart_done", 0, 1, 0, nb[i], 2'b10, 16'h4002, 1, 0, 4'd0, 0);
      else         cyc("restart_run", 0, 1, 0, nb[i], 2'b10, 16'h0F81, 0, 1, 4'(i + 1), 0);
    end
    cyc("restart_post", 0, 0, 0, 0, 2'b10, 16'h4002, 0, 0, 4'd0, 0);

    // Reset at channel 9 wins over en&sync.
    for (int i = 0; i < 9; i++)
      cyc("rstmid_pre", 0, 1, (i == 0), 1, 2'b10, 16'h4002, 0, 1, 4'(i + 1), 0);
    cyc("rstmid_reset", 1, 1, 1, 1, 2'b10, 16'h0000, 0, 0, 4'd0, 0);
    cyc("idle_en_nosync", 0, 1, 0, 1, 2'b01, 16'h0000, 0, 0, 4'd0, 0);
    cyc("idle_sync_noen", 0, 0, 1, 1, 2'b01, 16'h0000, 0, 0, 4'd0, 0);
    nb = 16'h005A;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) cyc("rstmid_done", 0, 1, 0, nb[i], 2'b01, 16'h005A, 1, 0, 4'd0, 0);
      else        cyc("rstmid_run", 0, 1, (i == 0), nb[i], 2'b01, 16'h0000, 0, 1, 4'(i + 1), 0);
    end
    cyc("rstmid_post", 0, 0, 0, 0, 2'b01, 16'h005A, 0, 0, 4'd0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
